morra_match_param: RTL



---
 rtl/morra_pkg.sv | 41 ++++
 rtl/morra_round_judge.sv | 36 +++
 rtl/morra_match_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/morra_pkg.sv
// Shared types and helpers for the rock-paper-scissors match controller.
package morra_pkg;

  // Move encoding on g1/g2
  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_t;

  // Per-round result
  typedef enum logic [1:0] {
    M_NONE = 2'b00,
    M_P1   = 2'b01,
    M_P2   = 2'b10,
    M_TIE  = 2'b11
  } manche_t;

  // Match result
  typedef enum logic [1:0] {
    P_PLAY = 2'b00,
    P_P1   = 2'b01,
    P_P2   = 2'b10,
    P_DRAW = 2'b11
  } partita_t;

  // Match controller state
  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // True when move a defeats move b (both assumed non-NONE)
  function automatic logic beats(input move_t a, input move_t b);
    return ((a == ROCK)     && (b == SCISSORS)) ||
           ((a == SCISSORS) && (b == PAPER))    ||
           ((a == PAPER)    && (b == ROCK));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational round judge: decides whether a round counts and who won it.
// A stored winning move of 00 never blocks, so tying the last-win inputs to
// 00 disables the blocking rule (used when MORRA_BLOCK_RULE_EN is undefined).
module morra_round_judge
  import morra_pkg::*;
(
  input  logic [1:0] i_g1,
  input  logic [1:0] i_g2,
  input  logic [1:0] i_last_win1,
  input  logic [1:0] i_last_win2,
  output logic       o_valid,
  output manche_t    o_outcome
);

  logic w_idle;
  logic w_blocked;

  assign w_idle    = (i_g1 == 2'b00) || (i_g2 == 2'b00);
  assign w_blocked = ((i_last_win1 != 2'b00) && (i_g1 == i_last_win1)) ||
                     ((i_last_win2 != 2'b00) && (i_g2 == i_last_win2));

  // Validity and winner of the presented moves
  always_comb begin
    o_valid   = !w_idle && !w_blocked;
    o_outcome = M_NONE;
    if (o_valid) begin
      if (i_g1 == i_g2)
        o_outcome = M_TIE;
      else if (beats(move_t'(i_g1), move_t'(i_g2)))
        o_outcome = M_P1;
      else
        o_outcome = M_P2;
    end
  end

endmodule

// File: rtl/morra_match_param.sv
// Parametrised two-player rock-paper-scissors match controller.
// Optional feature: define MORRA_BLOCK_RULE_EN to forbid a player from
// repeating their last winning move.
module morra_match_param
  import morra_pkg::*;
#(
  parameter int MIN_ROUNDS  = 4,
  parameter int LEAD_TO_WIN = 2,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       g1,
  input  logic [1:0]       g2,
  output logic [1:0]       manche,
  output logic [1:0]       partita,
  output logic [CNT_W-1:0] rounds,
  output logic [CNT_W-1:0] score1,
  output logic [CNT_W-1:0] score2
);

  localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0] LEAD  = CNT_W'(LEAD_TO_WIN);

  state_t           r_state,  w_state_next;
  manche_t          r_manche, w_manche_next;
  partita_t         r_partita, w_partita_next;
  logic [CNT_W-1:0] r_rounds, w_rounds_next;
  logic [CNT_W-1:0] r_score1, w_score1_next;
  logic [CNT_W-1:0] r_score2, w_score2_next;
  logic [CNT_W-1:0] r_max_rounds;
  logic [1:0]       w_last_win1, w_last_win2;
  logic [1:0]       w_last_win1_next, w_last_win2_next;
  logic             w_valid;
  manche_t          w_outcome;
  logic [CNT_W-1:0] w_lead;

`ifdef MORRA_BLOCK_RULE_EN
  logic [1:0] r_last_win1, r_last_win2;

  // Stored winning moves for the blocking rule
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_win1 <= 2'b00;
      r_last_win2 <= 2'b00;
    end else begin
      r_last_win1 <= w_last_win1_next;
      r_last_win2 <= w_last_win2_next;
    end
  end

  assign w_last_win1 = r_last_win1;
  assign w_last_win2 = r_last_win2;
`else
  // No history kept: zero never blocks a move
  assign w_last_win1 = 2'b00;
  assign w_last_win2 = 2'b00;
`endif

  morra_round_judge u_judge (
    .i_g1        (g1),
    .i_g2        (g2),
    .i_last_win1 (w_last_win1),
    .i_last_win2 (w_last_win2),
    .o_valid     (w_valid),
    .o_outcome   (w_outcome)
  );

  // Next-state, counter update and end-of-match decision
  always_comb begin
    w_state_next     = r_state;
    w_manche_next    = M_NONE;
    w_partita_next   = r_partita;
    w_rounds_next    = r_rounds;
    w_score1_next    = r_score1;
    w_score2_next    = r_score2;
    w_last_win1_next = w_last_win1;
    w_last_win2_next = w_last_win2;
    w_lead           = '0;

    if ((r_state == PLAY) && w_valid) begin
      w_manche_next = w_outcome;
      w_rounds_next = r_rounds + 1'b1;
      case (w_outcome)
        M_P1: begin
          w_score1_next    = r_score1 + 1'b1;
          w_last_win1_next = g1;
        end
        M_P2: begin
          w_score2_next    = r_score2 + 1'b1;
          w_last_win2_next = g2;
        end
        default: ;
      endcase

      // Decide using the counts as they will be after this edge
      w_lead = (w_score1_next >= w_score2_next) ? (w_score1_next - w_score2_next)
                                                : (w_score2_next - w_score1_next);
      if ((w_rounds_next >= MIN_N) && (w_lead >= LEAD)) begin
        w_partita_next = (w_score1_next > w_score2_next) ? P_P1 : P_P2;
      end else if (w_rounds_next == r_max_rounds) begin
        if (w_score1_next > w_score2_next)
          w_partita_next = P_P1;
        else if (w_score2_next > w_score1_next)
          w_partita_next = P_P2;
        else
          w_partita_next = P_DRAW;
      end

      if (w_partita_next != P_PLAY)
        w_state_next = OVER;
    end
  end

  // State, counters and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= PLAY;
      r_manche     <= M_NONE;
      r_partita    <= P_PLAY;
      r_rounds     <= '0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_max_rounds <= MIN_N + CNT_W'({g1, g2});
    end else begin
      r_state   <= w_state_next;
      r_manche  <= w_manche_next;
      r_partita <= w_partita_next;
      r_rounds  <= w_rounds_next;
      r_score1  <= w_score1_next;
      r_score2  <= w_score2_next;
    end
  end

  assign manche  = r_manche;
  assign partita = r_partita;
  assign rounds  = r_rounds;
  assign score1  = r_score1;
  assign score2  = r_score2;

endmodule
